// File: rtl/xpb_pkg.sv
// -----------------------------------------------------------------------------
// xpb_pkg
// Shared definitions for the xpb table writer:
//   - default geometry (entry width, table index width, serial limb width)
//   - limb-count derivation helper
//   - FSM state encoding
// The REDUCE state is always part of the encoding; it is only reachable when
// the design is built with XPB_BASE_REDUCE_EN defined.
// -----------------------------------------------------------------------------
package xpb_pkg;

   localparam int XPB_DATA_W = 1024;
   localparam int XPB_IDX_W  = 5;
   localparam int XPB_LIMB_W = 64;

   // Number of LIMB_W-wide limbs that make up one DATA_W operand.
   function automatic int xpb_num_limbs(input int data_w, input int limb_w);
      return data_w / limb_w;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REDUCE = 3'd1,
      ST_EMIT   = 3'd2,
      ST_ADD    = 3'd3,
      ST_FIN    = 3'd4
   } xpb_state_t;

endpackage

// File: rtl/xpb_limb_addsub.sv
// -----------------------------------------------------------------------------
// xpb_limb_addsub
// One limb slice of the serial modular adder: an add-with-carry whose limb
// result feeds straight into a subtract-with-borrow against the modulus limb.
// Purely combinational; the caller registers carry/borrow between limbs.
//
// Ports:
//   a_in, b_in    : addend limbs (b_in is forced to zero for a plain reduce)
//   n_in          : modulus limb subtracted from the sum limb
//   carry_in      : carry from the previous (less significant) limb
//   borrow_in     : borrow from the previous limb of the subtract chain
//   sum_out       : (a + b + carry_in) mod 2^LIMB_W
//   carry_out     : carry out of the add
//   diff_out      : (sum_out - n - borrow_in) mod 2^LIMB_W
//   borrow_out    : borrow out of the subtract
// -----------------------------------------------------------------------------
module xpb_limb_addsub
   import xpb_pkg::*;
#(
   parameter int LIMB_W = XPB_LIMB_W
) (
   input  logic [LIMB_W-1:0] a_in,
   input  logic [LIMB_W-1:0] b_in,
   input  logic [LIMB_W-1:0] n_in,
   input  logic              carry_in,
   input  logic              borrow_in,
   output logic [LIMB_W-1:0] sum_out,
   output logic              carry_out,
   output logic [LIMB_W-1:0] diff_out,
   output logic              borrow_out
);

   logic [LIMB_W:0] sum_w;
   logic [LIMB_W:0] diff_w;

   always_comb begin
      sum_w  = {1'b0, a_in} + {1'b0, b_in} + {{LIMB_W{1'b0}}, carry_in};
      // One extra bit on the subtract: it wraps to 1 exactly when the
      // limb result went negative, which is the borrow.
      diff_w = {1'b0, sum_w[LIMB_W-1:0]} - {1'b0, n_in} - {{LIMB_W{1'b0}}, borrow_in};
   end

   assign sum_out    = sum_w[LIMB_W-1:0];
   assign carry_out  = sum_w[LIMB_W];
   assign diff_out   = diff_w[LIMB_W-1:0];
   assign borrow_out = diff_w[LIMB_W];

endmodule

// File: rtl/xpb_table_writer.sv
// -----------------------------------------------------------------------------
// xpb_table_writer
// Streams the 2^IDX_W entries k*C mod N (k = 0 .. 2^IDX_W-1) on a valid/ready
// write port. Each step adds C to the running accumulator one limb per cycle
// (LSB limb first) while simultaneously subtracting N, then keeps whichever of
// sum / sum-N is the correctly reduced value.
//
// Build option:
//   XPB_BASE_REDUCE_EN - when defined, a REDUCE phase runs one limb-serial
//                        conditional subtract C := C - N (if C >= N) before
//                        entry 0, so C may be anywhere below 2N. Adds
//                        NUM_LIMBS cycles before the first entry.
//                        When undefined, C < N is required.
//
// Ports:
//   clk       : sole clock
//   reset     : asynchronous, active-high; abandons any table in flight
//   start     : one-cycle request, only honoured while idle
//   base_in   : C, captured on accepted start
//   mod_in    : N (odd, non-zero), captured on accepted start
//   busy      : high from the cycle after the accepted start until done
//   done      : one-cycle pulse after the last entry is handed over
//   wr_valid  : an entry is presented
//   wr_ready  : sink accepts the presented entry
//   wr_addr   : entry index k
//   wr_data   : entry value k*C mod N
// -----------------------------------------------------------------------------
module xpb_table_writer
   import xpb_pkg::*;
#(
   parameter int DATA_W = XPB_DATA_W,
   parameter int IDX_W  = XPB_IDX_W,
   parameter int LIMB_W = XPB_LIMB_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] base_in,
   input  logic [DATA_W-1:0] mod_in,
   output logic              busy,
   output logic              done,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [IDX_W-1:0]  wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   localparam int NUM_LIMBS = xpb_num_limbs(DATA_W, LIMB_W);
   localparam int LC_W      = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
   localparam int SR_W      = DATA_W - LIMB_W;

   localparam logic [LC_W-1:0]  LIMB_LAST = LC_W'(NUM_LIMBS - 1);
   localparam logic [IDX_W-1:0] K_LAST    = {IDX_W{1'b1}};

   generate
      if (((DATA_W % LIMB_W) != 0) || (NUM_LIMBS < 2)) begin : g_bad_cfg
         $error("xpb_table_writer: DATA_W must be a multiple of LIMB_W with at least two limbs");
      end
   endgenerate

   // ---------------------------------------------------------------- state
   xpb_state_t state_q, state_d;

   // ------------------------------------------------------------- datapath
   logic [DATA_W-1:0] base_q, base_d;       // C, rotated one limb per serial cycle
   logic [DATA_W-1:0] mod_q, mod_d;         // N, rotated one limb per serial cycle
   logic [DATA_W-1:0] acc_q, acc_d;         // current entry value
   logic [SR_W-1:0]   sum_sr_q, sum_sr_d;   // completed sum limbs, newest on top
   logic [SR_W-1:0]   diff_sr_q, diff_sr_d; // completed diff limbs, newest on top
   logic              carry_q, carry_d;
   logic              borrow_q, borrow_d;
   logic [LC_W-1:0]   limb_q, limb_d;
   logic [IDX_W-1:0]  k_q, k_d;

   logic [LIMB_W-1:0] op_a;
   logic [LIMB_W-1:0] op_b;
   logic [LIMB_W-1:0] op_n;
   logic              cin;
   logic              bin;
   logic [LIMB_W-1:0] sum_limb;
   logic [LIMB_W-1:0] diff_limb;
   logic              cout;
   logic              bout;
   logic [DATA_W-1:0] sum_full;
   logic [DATA_W-1:0] diff_full;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] base_rot;
   logic [DATA_W-1:0] mod_rot;
   logic              last_limb;
   logic              take_diff;

   // Operand selection for the shared limb slice. ADD adds the current
   // accumulator limb to the C limb; REDUCE pushes C through with a zero
   // addend so only the subtract of N is effective.
   always_comb begin
      op_a = acc_q[int'(limb_q) * LIMB_W +: LIMB_W];
      op_b = base_q[LIMB_W-1:0];
`ifdef XPB_BASE_REDUCE_EN
      if (state_q == ST_REDUCE) begin
         op_a = base_q[LIMB_W-1:0];
         op_b = '0;
      end
`endif
      op_n = mod_q[LIMB_W-1:0];
      // Chains start fresh on limb 0; the registered carry/borrow still hold
      // the previous operation's final values at that point.
      cin  = (limb_q == '0) ? 1'b0 : carry_q;
      bin  = (limb_q == '0) ? 1'b0 : borrow_q;
   end

   xpb_limb_addsub #(
      .LIMB_W     (LIMB_W)
   ) u_addsub (
      .a_in       (op_a),
      .b_in       (op_b),
      .n_in       (op_n),
      .carry_in   (cin),
      .borrow_in  (bin),
      .sum_out    (sum_limb),
      .carry_out  (cout),
      .diff_out   (diff_limb),
      .borrow_out (bout)
   );

   always_comb begin
      sum_full  = {sum_limb, sum_sr_q};
      diff_full = {diff_limb, diff_sr_q};
      base_rot  = {base_q[LIMB_W-1:0], base_q[DATA_W-1:LIMB_W]};
      mod_rot   = {mod_q[LIMB_W-1:0], mod_q[DATA_W-1:LIMB_W]};
      last_limb = (limb_q == LIMB_LAST);
      // sum >= N exactly when the add overflowed DATA_W bits or the
      // subtract of N did not borrow; then sum - N is the reduced value.
      take_diff = cout | ~bout;
      result    = take_diff ? diff_full : sum_full;
   end

   // Datapath next-state.
   always_comb begin
      base_d    = base_q;
      mod_d     = mod_q;
      acc_d     = acc_q;
      sum_sr_d  = sum_sr_q;
      diff_sr_d = diff_sr_q;
      carry_d   = carry_q;
      borrow_d  = borrow_q;
      limb_d    = limb_q;
      k_d       = k_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d = base_in;
               mod_d  = mod_in;
               acc_d  = '0;
               k_d    = '0;
               limb_d = '0;
            end
         end
`ifdef XPB_BASE_REDUCE_EN
         ST_REDUCE: begin
            mod_d     = mod_rot;
            sum_sr_d  = sum_full[DATA_W-1:LIMB_W];
            diff_sr_d = diff_full[DATA_W-1:LIMB_W];
            carry_d   = cout;
            borrow_d  = bout;
            if (last_limb) begin
               base_d = result;
               limb_d = '0;
            end else begin
               base_d = base_rot;
               limb_d = limb_q + LC_W'(1);
            end
         end
`endif
         ST_ADD: begin
            // After NUM_LIMBS rotations C and N are back in their home
            // positions, ready for the next entry.
            base_d    = base_rot;
            mod_d     = mod_rot;
            sum_sr_d  = sum_full[DATA_W-1:LIMB_W];
            diff_sr_d = diff_full[DATA_W-1:LIMB_W];
            carry_d   = cout;
            borrow_d  = bout;
            if (last_limb) begin
               acc_d  = result;
               k_d    = k_q + IDX_W'(1);
               limb_d = '0;
            end else begin
               limb_d = limb_q + LC_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

   // FSM next-state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
`ifdef XPB_BASE_REDUCE_EN
               state_d = ST_REDUCE;
`else
               state_d = ST_EMIT;
`endif
            end
         end
`ifdef XPB_BASE_REDUCE_EN
         ST_REDUCE: begin
            if (last_limb) begin
               state_d = ST_EMIT;
            end
         end
`endif
         ST_EMIT: begin
            if (wr_ready) begin
               state_d = (k_q == K_LAST) ? ST_FIN : ST_ADD;
            end
         end
         ST_ADD: begin
            if (last_limb) begin
               state_d = ST_EMIT;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_FIN);
      wr_valid = (state_q == ST_EMIT);
   end

   // acc and k only change in IDLE/ADD, so they hold steady across a stall.
   assign wr_addr = k_q;
   assign wr_data = acc_q;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q    <= '0;
         mod_q     <= '0;
         acc_q     <= '0;
         sum_sr_q  <= '0;
         diff_sr_q <= '0;
         carry_q   <= 1'b0;
         borrow_q  <= 1'b0;
         limb_q    <= '0;
         k_q       <= '0;
      end else begin
         base_q    <= base_d;
         mod_q     <= mod_d;
         acc_q     <= acc_d;
         sum_sr_q  <= sum_sr_d;
         diff_sr_q <= diff_sr_d;
         carry_q   <= carry_d;
         borrow_q  <= borrow_d;
         limb_q    <= limb_d;
         k_q       <= k_d;
      end
   end

endmodule

// File: tb/tb_xpb_table_writer.sv
// -----------------------------------------------------------------------------
// tb_xpb_table_writer
// Small-geometry bench (DATA_W=16, LIMB_W=4, IDX_W=5). Each table run pushes
// the 32 expected entries (k*C mod N, computed arithmetically) into a queue;
// a negedge monitor pops and compares on every handshake and checks that a
// stalled entry holds still. A run table drives the stimulus and a spot table
// holds hand-derived entry values. Reset-mid-table is a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_xpb_table_writer;

   localparam int DW    = 16;
   localparam int IW    = 5;
   localparam int LW    = 4;
   localparam int NL    = DW / LW;
   localparam int STEP  = NL + 1;
   localparam int DEPTH = 1 << IW;
`ifdef XPB_BASE_REDUCE_EN
   localparam int LAT = NL;
`else
   localparam int LAT = 0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] base_in = '0;
   logic [DW-1:0] mod_in = '0;
   logic          busy;
   logic          done;
   logic          wr_valid;
   logic          wr_ready = 1'b1;
   logic [IW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   xpb_table_writer #(
      .DATA_W   (DW),
      .IDX_W    (IW),
      .LIMB_W   (LW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .base_in  (base_in),
      .mod_in   (mod_in),
      .busy     (busy),
      .done     (done),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [IW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   typedef struct {
      logic [DW-1:0] c;
      logic [DW-1:0] n;
      bit            bp;
      bit            poke;
   } run_t;

   typedef struct {
      int            run;
      logic [IW-1:0] addr;
      logic [DW-1:0] exp;
   } spot_t;

   ent_t  sb[$];
   run_t  runs[$];
   spot_t spots[$];

   // monitor state
   bit            mon_en = 1'b0;
   bit            bp_mode = 1'b0;
   bit            stall_prev = 1'b0;
   logic [IW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_data = '0;
   logic [DW-1:0] got [DEPTH];
   int            first_valid [DEPTH];
   bit            seen [DEPTH];
   int            hs_count = 0;
   int            hs_last_cyc = 0;
   int            done_count = 0;
   int            done_cyc = 0;

   // Random backpressure, changed just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         wr_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      ent_t e;
      if (mon_en) begin
         if (stall_prev) begin
            chk("stall_valid", 32'(wr_valid), 32'd1);
            chk("stall_addr", 32'(wr_addr), 32'(prev_addr));
            chk("stall_data", 32'(wr_data), 32'(prev_data));
         end
         if (wr_valid && !seen[wr_addr]) begin
            seen[wr_addr]        = 1'b1;
            first_valid[wr_addr] = cyc;
         end
         if (wr_valid && wr_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_write", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("wr_addr", 32'(wr_addr), 32'(e.addr));
               chk("wr_data", 32'(wr_data), 32'(e.data));
            end
            got[wr_addr] = wr_data;
            hs_count++;
            hs_last_cyc = cyc;
         end
         if (done) begin
            done_count++;
            done_cyc = cyc;
         end
         stall_prev = wr_valid && !wr_ready;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
      end
   end

   task automatic run_table(input int idx);
      int            t0;
      bit            ok;
      logic [DW-1:0] c;
      logic [DW-1:0] n;
      c = runs[idx].c;
      n = runs[idx].n;
      sb.delete();
      for (int k = 0; k < DEPTH; k++) begin
         seen[k]        = 1'b0;
         got[k]         = '0;
         first_valid[k] = -1;
         sb.push_back('{addr: IW'(k), data: DW'((longint'(k) * (longint'(c) % longint'(n))) % longint'(n))});
      end
      hs_count   = 0;
      done_count = 0;
      stall_prev = 1'b0;
      bp_mode    = runs[idx].bp;

      @(posedge clk);
      #1;
      start   = 1'b1;
      base_in = c;
      mod_in  = n;
      mon_en  = 1'b1;
      @(negedge clk);
      t0 = cyc;
      @(posedge clk);
      #1;
      start   = 1'b0;
      base_in = ~c;
      mod_in  = 16'hFFFF;
      @(negedge clk);
      #2;
      chk("busy_at_1", 32'(busy), 32'd1);
      chk("valid_at_1", 32'(wr_valid), (LAT == 0) ? 32'd1 : 32'd0);

      if (runs[idx].poke) begin
         repeat (7) @(posedge clk);
         #1;
         start   = 1'b1;
         base_in = 16'h0BAD;
         mod_in  = 16'h0007;
         @(posedge clk);
         #1;
         start = 1'b0;
      end

      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         #2;
         if (done_count > 0) ok = 1'b1;
      end
      chk("done_seen", 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      #2;
      mon_en = 1'b0;
      chk("done_once", 32'(done_count), 32'd1);
      chk("write_count", 32'(hs_count), 32'(DEPTH));
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("done_after_last_hs", 32'(done_cyc), 32'(hs_last_cyc + 1));
      if (!runs[idx].bp) begin
         chk("first_valid_k0", 32'(first_valid[0]), 32'(t0 + 1 + LAT));
         chk("first_valid_k31", 32'(first_valid[DEPTH-1]), 32'(t0 + 1 + LAT + (DEPTH - 1) * STEP));
         chk("done_cycle", 32'(done_cyc), 32'(t0 + 2 + LAT + (DEPTH - 1) * STEP));
      end
      foreach (spots[s]) begin
         if (spots[s].run == idx) begin
            chk($sformatf("run%0d_addr%0d", idx, spots[s].addr), 32'(got[spots[s].addr]), 32'(spots[s].exp));
         end
      end
      $display("run %0d: C=0x%04h N=0x%04h bp=%0d writes=%0d done_cyc=%0d", idx, c, n, runs[idx].bp, hs_count, done_cyc);
   endtask

   initial begin
      bit found;

      runs.push_back('{c: 16'h1234, n: 16'hFFF1, bp: 1'b0, poke: 1'b0});
      runs.push_back('{c: 16'hFFF0, n: 16'hFFF1, bp: 1'b0, poke: 1'b0});
      runs.push_back('{c: 16'h1234, n: 16'hFFF1, bp: 1'b1, poke: 1'b1});
      runs.push_back('{c: 16'h0001, n: 16'hFFF1, bp: 1'b0, poke: 1'b0});
`ifdef XPB_BASE_REDUCE_EN
      runs.push_back('{c: 16'hFFF5, n: 16'hFFF1, bp: 1'b0, poke: 1'b1});
`endif

      spots.push_back('{run: 0, addr: 5'd0,  exp: 16'h0000});
      spots.push_back('{run: 0, addr: 5'd1,  exp: 16'h1234});
      spots.push_back('{run: 0, addr: 5'd2,  exp: 16'h2468});
      spots.push_back('{run: 0, addr: 5'd15, exp: 16'h111B});
      spots.push_back('{run: 0, addr: 5'd31, exp: 16'h346A});
      spots.push_back('{run: 1, addr: 5'd1,  exp: 16'hFFF0});
      spots.push_back('{run: 1, addr: 5'd2,  exp: 16'hFFEF});
      spots.push_back('{run: 1, addr: 5'd3,  exp: 16'hFFEE});
      spots.push_back('{run: 2, addr: 5'd0,  exp: 16'h0000});
      spots.push_back('{run: 2, addr: 5'd15, exp: 16'h111B});
      spots.push_back('{run: 2, addr: 5'd31, exp: 16'h346A});
      spots.push_back('{run: 3, addr: 5'd0,  exp: 16'h0000});
      spots.push_back('{run: 3, addr: 5'd7,  exp: 16'h0007});
      spots.push_back('{run: 3, addr: 5'd31, exp: 16'h001F});
      spots.push_back('{run: 4, addr: 5'd1,  exp: 16'h0004});
      spots.push_back('{run: 4, addr: 5'd3,  exp: 16'h000C});

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Back-to-back table runs.
      for (int r = 0; r < 3; r++) begin
         run_table(r);
      end

      // Reset while the entry after index 7 is being computed.
      bp_mode = 1'b0;
      @(posedge clk);
      #1;
      start   = 1'b1;
      base_in = 16'h1234;
      mod_in  = 16'hFFF1;
      @(posedge clk);
      #1;
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk);
         if (busy && !wr_valid && wr_addr == 5'd7) found = 1'b1;
      end
      chk("reached_k7_add", 32'(found), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_wr_valid", 32'(wr_valid), 32'd0);
      chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
      chk("midrst_wr_data", 32'(wr_data), 32'd0);
      $display("reset applied mid-table at k=7: busy=%0d wr_valid=%0d", busy, wr_valid);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Fresh table after the abandoned one, then the optional reduce run.
      for (int r = 3; r < runs.size(); r++) begin
         run_table(r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
